led_frame_seq: RTL and testbench
================================

Name: led_frame_seq

Overview:
- Frame sequencer that drives the 8-bit frame index consumed by the 8x8 LED matrix glyph/scan block.
- Steps the index through a programmable range [start_idx..end_idx] with a per-frame dwell time.
- Supports play, pause, single-step, stop and loop.
- Commits frame changes only on the scanner's frame-boundary pulse, so a glyph is never split mid-scan (no tearing).

Parameters:
- DWELL_CYCLES, 50_000_000, base clk cycles per frame (1 s at 50 MHz); legal range 2..2^30.
- IDLE_IDX, 8'd10, frame index shown in IDLE and after reset.
- CNT_W, 32, dwell counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begin sequence (ignored unless IDLE or DONE).
- stop  input  1  pulse; abort to IDLE from any state.
- pause  input  1  level; freeze sequence while high.
- step  input  1  pulse; advance one frame, honoured only in PAUSE.
- loop_en  input  1  level; 1 = wrap end_idx->start_idx, 0 = finish at end_idx.
- start_idx  input  8  first frame index, latched on accepted start.
- end_idx  input  8  last frame index, latched on accepted start.
- dwell_sel  input  2  dwell scale: 00 x1, 01 x2, 10 x4, 11 x0.5 (DWELL_CYCLES>>1).
- frame_sync  input  1  one-cycle pulse from scanner at end of row 8.
- led_state  output  8  frame index to glyph/scan block.
- busy  output  1  high in RUN, HOLD, PAUSE.
- done  output  1  one-cycle pulse when a non-loop sequence completes.
- err  output  1  one-cycle pulse when start is rejected (start_idx > end_idx).

Behaviour:
- Reset (async, rst=1): state IDLE, led_state=IDLE_IDX, busy=0, done=0, err=0, counter=0, latched range=0. Reset mid-sequence drops to IDLE immediately; no done pulse.
- Command priority, highest first: stop > start > pause > step.
- States: IDLE, RUN, HOLD, PAUSE, DONE.
- IDLE/DONE + start:
  - start_idx <= end_idx: latch range and dwell_sel scale; next cycle led_state=start_idx, counter=0, state=RUN.
  - Otherwise: err pulse next cycle, state unchanged, led_state unchanged.
- RUN: counter increments each cycle. At counter == scaled_dwell-1 -> HOLD, counter holds.
- scaled_dwell is computed in CNT_W bits, saturating at 2^CNT_W-1, and re-sampled from dwell_sel at every frame advance.
- HOLD: waits for frame_sync. On frame_sync, the advance rule applies and counter clears.
  - frame_sync coinciding with the terminal-count cycle in RUN does not count; the next frame_sync does. Maximum frame time is therefore dwell + one scan period.
- Advance rule:
  - led_state != end_idx: led_state+1.
  - led_state == end_idx and loop_en=1: led_state=start_idx, stay RUN.
  - led_state == end_idx and loop_en=0: led_state held, done pulse, state=DONE.
- Degenerate range: start_idx == end_idx with loop_en=1 re-shows the same frame every dwell; no done pulse.
- pause high in RUN or HOLD -> PAUSE. Counter frozen, led_state held. pause low -> return to the saved RUN/HOLD state with the counter intact.
- PAUSE + step: apply the advance rule at the next frame_sync, clear counter, remain PAUSE. If the rule reaches DONE: done pulse, state=DONE.
  - A step pulse is remembered until the frame_sync that serves it.
  - A second step before that frame_sync is ignored.
  - A pending step is cleared by stop.
- DONE: led_state holds end_idx, busy=0. New start restarts; stop -> IDLE.
- stop in any state: next cycle IDLE, led_state=IDLE_IDX, counter=0, pending step cleared, no done.
- led_state is 8-bit unsigned and never exceeds end_idx while busy. No index arithmetic wraps past 255, since end_idx <= 255 bounds it.
- All outputs are registered; command-to-output latency is 1 cycle.

Decomposition:
- Shared package led_pkg:
  - state enum (IDLE, RUN, HOLD, PAUSE, DONE)
  - dwell_sel encodings
  - IDLE_IDX default
  - the frame-index width constant (8), also used by the glyph/scan block.
- One natural sub-module, led_dwell_timer: scaled-dwell computation, counter, freeze and clear inputs, terminal-count output.

Test Plan (bench uses DWELL_CYCLES=10, frame_sync every 16 cycles):
- Reset then idle -> led_state=10, busy=0. Assert rst mid-RUN -> led_state=10 in the same cycle, no done.
- start with start_idx=2, end_idx=4, loop_en=0, dwell_sel=00 -> led_state 2,3,4. Each advance occurs at the first frame_sync at least 10 cycles after the prior advance. Then one done pulse, state DONE, led_state=4, busy=0.
- Same range with loop_en=1, dwell_sel=10 -> sequence 2,3,4,2,3 with at least 40 cycles per frame; done never asserts.
- start_idx=9, end_idx=3 -> err pulse 1 cycle later, led_state stays 10, busy=0.
- RUN at idx 3: pause high for 100 cycles, then step twice within one scan period -> exactly one advance to 4 at the next frame_sync. Release pause -> dwell resumes from counter 0.
- Same-cycle stop+start while in RUN -> IDLE with led_state=10. Same-cycle pause+step in RUN -> PAUSE entered, step ignored, led_state unchanged.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame sequencer and the glyph/scan block.
package led_pkg;

  localparam int IDX_W = 8;
  localparam logic [IDX_W-1:0] IDLE_IDX_DEF = 8'd10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    DWELL_X1   = 2'b00,
    DWELL_X2   = 2'b01,
    DWELL_X4   = 2'b10,
    DWELL_HALF = 2'b11
  } dwell_sel_e;

endpackage

// File: rtl/led_dwell_timer.sv
// Per-frame dwell timer: scales the base dwell, counts up while enabled and
// holds at terminal count until the sequencer reloads or clears it.
module led_dwell_timer
  import led_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int          CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clr,
  input  logic       run,
  input  logic [1:0] dwell_sel,
  output logic       tc
);

  localparam logic [63:0] BASE = 64'(DWELL_CYCLES);
  localparam logic [63:0] SAT  = (64'd1 << CNT_W) - 64'd1;

  logic [63:0]      scaled_wide;
  logic [CNT_W-1:0] scaled_next;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] cnt_q;

  // Computed wide so x2/x4 of a large base saturates instead of wrapping.
  always_comb begin
    scaled_wide = BASE;
    case (dwell_sel)
      DWELL_X2:   scaled_wide = BASE << 1;
      DWELL_X4:   scaled_wide = BASE << 2;
      DWELL_HALF: scaled_wide = BASE >> 1;
      default:    scaled_wide = BASE;
    endcase
    scaled_next = (scaled_wide > SAT) ? SAT[CNT_W-1:0] : scaled_wide[CNT_W-1:0];
  end

  assign tc = (cnt_q == (dwell_q - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      dwell_q <= '0;
    end else if (load) begin
      cnt_q   <= '0;
      dwell_q <= scaled_next;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run && !tc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_frame_seq.sv
// Frame sequencer for the 8x8 LED matrix: steps a frame index through a
// programmed range, committing changes only on the scanner frame boundary.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | parked on IDLE_IDX, waiting for start
//   ST_RUN   | dwell timer counting for the current frame
//   ST_HOLD  | dwell expired, waiting for frame_sync to advance
//   ST_PAUSE | frozen; a pending step advances at the next frame_sync
//   ST_DONE  | non-loop sequence finished, holding end index
module led_frame_seq
  import led_pkg::*;
#(
  parameter int unsigned       DWELL_CYCLES = 50_000_000,
  parameter logic [IDX_W-1:0]  IDLE_IDX     = IDLE_IDX_DEF,
  parameter int                CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             step,
  input  logic             loop_en,
  input  logic [IDX_W-1:0] start_idx,
  input  logic [IDX_W-1:0] end_idx,
  input  logic [1:0]       dwell_sel,
  input  logic             frame_sync,
  output logic [IDX_W-1:0] led_state,
  output logic             busy,
  output logic             done,
  output logic             err
);

  seq_state_e       state_q, state_d;
  seq_state_e       saved_q, saved_d;
  logic [IDX_W-1:0] led_q, led_d;
  logic [IDX_W-1:0] start_q, start_d;
  logic [IDX_W-1:0] end_q, end_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             step_pend_q, step_pend_d;
  logic             t_load, t_clr, t_run, tc;
  logic             at_end, fin;
  logic [IDX_W-1:0] adv_idx;

  led_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (t_load),
    .clr       (t_clr),
    .run       (t_run),
    .dwell_sel (dwell_sel),
    .tc        (tc)
  );

  assign at_end  = (led_q == end_q);
  assign fin     = at_end && !loop_en;
  assign adv_idx = at_end ? start_q : (led_q + 8'd1);

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    led_d       = led_q;
    start_d     = start_q;
    end_d       = end_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    step_pend_d = step_pend_q;
    t_load      = 1'b0;
    t_clr       = 1'b0;
    t_run       = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      led_d       = IDLE_IDX;
      step_pend_d = 1'b0;
      t_clr       = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (start_idx <= end_idx) begin
              state_d = ST_RUN;
              led_d   = start_idx;
              start_d = start_idx;
              end_d   = end_idx;
              t_load  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
            saved_d = ST_RUN;
          end else if (tc) begin
            state_d = ST_HOLD;
          end else begin
            t_run = 1'b1;
          end
        end
        ST_HOLD: begin
          if (pause) begin
            state_d = ST_PAUSE;
            saved_d = ST_HOLD;
          end else if (frame_sync) begin
            t_load = 1'b1;
            if (fin) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
              led_d   = adv_idx;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d     = saved_q;
            step_pend_d = 1'b0;
          end else if (step_pend_q && frame_sync) begin
            // The stepped frame starts a fresh dwell once pause is released.
            t_load      = 1'b1;
            step_pend_d = 1'b0;
            saved_d     = ST_RUN;
            if (fin) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              led_d = adv_idx;
            end
          end else if (step) begin
            step_pend_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      saved_q     <= ST_IDLE;
      led_q       <= IDLE_IDX;
      start_q     <= '0;
      end_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      led_q       <= led_d;
      start_q     <= start_d;
      end_q       <= end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      step_pend_q <= step_pend_d;
    end
  end

  assign led_state = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_led_frame_seq.sv
// Scoreboard bench for led_frame_seq: expected frame indices are queued as
// commands are issued and matched, with their commit edge, as led_state moves.
module tb_led_frame_seq;

  logic       clk, rst, start, stop, pause, step, loop_en, frame_sync;
  logic [7:0] start_idx, end_idx, led_state;
  logic [1:0] dwell_sel;
  logic       busy, done, err;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int last_adv = 0;
  int exp_dwell = 10;
  int done_cnt = 0;
  int done_edge = 0;
  int done_base, rel_edge, n;
  bit tmode = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_led = 8'd10;
  logic       prev_busy = 1'b0;

  led_frame_seq #(
    .DWELL_CYCLES (10),
    .IDLE_IDX     (8'd10),
    .CNT_W        (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .step       (step),
    .loop_en    (loop_en),
    .start_idx  (start_idx),
    .end_idx    (end_idx),
    .dwell_sel  (dwell_sel),
    .frame_sync (frame_sync),
    .led_state  (led_state),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, expv, cyc);
    end
  endtask

  // First frame_sync edge at or after edge t (frame_sync lands on every 16th edge).
  function automatic int next_fs(input int t);
    int k = t;
    while (k % 16 != 0) k++;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input string tag, input int max);
    int i = 0;
    while (exp_q.size() != 0 && i < max) begin
      tick();
      i++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int target, input int max);
    int i = 0;
    while (done_cnt < target && i < max) begin
      tick();
      i++;
    end
    check_eq(tag, 32'(done_cnt), 32'(target));
  endtask

  // Monitor: edge k's results are observed at the following negedge; then
  // frame_sync is driven for edge k+1.
  initial begin
    frame_sync = 1'b0;
    forever begin
      @(negedge clk);
      if (led_state !== prev_led) begin
        if (exp_q.size() == 0) check_eq("led_extra", 32'(exp_q.size()), 32'd1);
        else check_eq("led_seq", 32'(led_state), 32'(exp_q.pop_front()));
        if (tmode && busy && prev_busy)
          check_eq("adv_edge", 32'(cyc), 32'(next_fs(last_adv + exp_dwell + 1)));
        last_adv = cyc;
      end else if (busy && !prev_busy) begin
        last_adv = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_edge = cyc;
        if (tmode) check_eq("done_edge", 32'(cyc), 32'(next_fs(last_adv + exp_dwell + 1)));
      end
      prev_led  = led_state;
      prev_busy = busy;
      cyc++;
      frame_sync = (cyc % 16 == 0);
    end
  end

  initial begin
    rst = 1'b1; start = 0; stop = 0; pause = 0; step = 0; loop_en = 0;
    start_idx = 8'd0; end_idx = 8'd0; dwell_sel = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_led", 32'(led_state), 32'd10);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // one-shot 2..4, dwell x1
    tmode = 1'b1; exp_dwell = 10;
    start_idx = 8'd2; end_idx = 8'd4; loop_en = 0; dwell_sel = 2'b00;
    exp_q.push_back(8'd2); exp_q.push_back(8'd3); exp_q.push_back(8'd4);
    start = 1; tick(); start = 0;
    check_eq("start_led", 32'(led_state), 32'd2);
    check_eq("start_busy", 32'(busy), 32'd1);
    wait_done("once_done", 1, 200);
    check_eq("once_q", 32'(exp_q.size()), 32'd0);
    check_eq("once_led", 32'(led_state), 32'd4);
    check_eq("once_busy", 32'(busy), 32'd0);
    check_eq("once_pulse", 32'(done), 32'd0);

    // loop 2..4, dwell x4, from DONE
    exp_dwell = 40; loop_en = 1; dwell_sel = 2'b10; done_base = done_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'((i % 3) + 2));
    tick(); start = 1; tick(); start = 0;
    wait_q("loop_q", 400);
    check_eq("loop_nodone", 32'(done_cnt), 32'(done_base));
    check_eq("loop_busy", 32'(busy), 32'd1);
    exp_q.push_back(8'd10);
    stop = 1; tick(); stop = 0;
    check_eq("stop_led", 32'(led_state), 32'd10);
    check_eq("stop_busy", 32'(busy), 32'd0);
    loop_en = 0;

    // rejected range
    tick();
    start_idx = 8'd9; end_idx = 8'd3; start = 1; tick(); start = 0;
    check_eq("err_pulse", 32'(err), 32'd1);
    check_eq("err_led", 32'(led_state), 32'd10);
    check_eq("err_busy", 32'(busy), 32'd0);
    tick();
    check_eq("err_clear", 32'(err), 32'd0);

    // half dwell, 0..1
    exp_dwell = 5; dwell_sel = 2'b11; done_base = done_cnt;
    start_idx = 8'd0; end_idx = 8'd1;
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    start = 1; tick(); start = 0;
    wait_done("half_done", done_base + 1, 100);
    check_eq("half_led", 32'(led_state), 32'd1);
    exp_q.push_back(8'd10);
    stop = 1; tick(); stop = 0;
    check_eq("half_stop", 32'(led_state), 32'd10);

    // pause at idx 3, double step, release
    exp_dwell = 10; dwell_sel = 2'b00; done_base = done_cnt;
    start_idx = 8'd2; end_idx = 8'd4;
    exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    start = 1; tick(); start = 0;
    wait_q("pause_pre", 100);
    tmode = 1'b0;
    pause = 1;
    repeat (100) tick();
    check_eq("pause_led", 32'(led_state), 32'd3);
    check_eq("pause_busy", 32'(busy), 32'd1);
    n = 0;
    do begin @(posedge clk); n++; end while (!frame_sync && n < 40);
    #1;
    exp_q.push_back(8'd4);
    step = 1; tick(); step = 0;
    tick(); tick();
    step = 1; tick(); step = 0;
    wait_q("step_q", 20);
    repeat (40) tick();
    check_eq("step_once", 32'(led_state), 32'd4);
    check_eq("step_busy", 32'(busy), 32'd1);
    check_eq("step_nodone", 32'(done_cnt), 32'(done_base));
    pause = 0;
    rel_edge = cyc + 1;
    wait_done("resume_done", done_base + 1, 100);
    check_eq("resume_edge", 32'(done_edge), 32'(next_fs(rel_edge + 11)));

    // same-cycle stop+start, then pause+step in RUN
    exp_q.push_back(8'd2);
    tick(); start = 1; tick(); start = 0;
    wait_q("ss_pre", 20);
    repeat (3) tick();
    exp_q.push_back(8'd10);
    stop = 1; start = 1; tick(); stop = 0; start = 0;
    check_eq("ss_led", 32'(led_state), 32'd10);
    tick();
    check_eq("ss_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'd2);
    start = 1; tick(); start = 0;
    repeat (3) tick();
    pause = 1; step = 1; tick(); step = 0;
    repeat (40) tick();
    check_eq("ps_led", 32'(led_state), 32'd2);
    check_eq("ps_busy", 32'(busy), 32'd1);
    exp_q.push_back(8'd10);
    stop = 1; tick(); stop = 0; pause = 0;
    check_eq("ps_stop", 32'(led_state), 32'd10);

    // async reset mid-RUN
    done_base = done_cnt;
    exp_q.push_back(8'd2);
    start = 1; tick(); start = 0;
    repeat (5) tick();
    exp_q.push_back(8'd10);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_led", 32'(led_state), 32'd10);
    check_eq("arst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    repeat (30) tick();
    check_eq("arst_nodone", 32'(done_cnt), 32'(done_base));
    check_eq("arst_idle", 32'(led_state), 32'd10);

    repeat (3) tick();
    check_eq("q_final", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
